uart_tx_ctrl: RTL

UART transmit frame sequencer driven by the 16x oversampling tick from the baud clock generator. It accepts one byte over a valid/ready handshake and serialises it onto txd as start, data (LSB first), optional parity and stop bits. It owns the generator's start input: it holds the baud counter cleared while idle, so the first bit of each frame is phase-aligned to the accept. It sits between the APB-side TX buffer and the pad.

---
 rtl/uart_tx_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer.
// Serialises one accepted byte as start, data (LSB first), optional parity and
// one or two stop bits, timed by the 16x oversampling tick. While idle it holds
// the baud generator cleared so each frame's first bit is aligned to the accept.
module uart_tx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk_tick,
    output logic              bclk_start,
    input  logic [1:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state_r;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [BIT_W-1:0]    bit_cnt_r;
    logic                stop_cnt_r;
    logic [DATA_W-1:0]   shreg_r;
    logic [1:0]          data_bits_r;
    logic                parity_en_r;
    logic                stop2_r;
    logic                parity_r;

    logic                bit_end_s;
    logic [BIT_W-1:0]    last_bit_s;

    // Parity over the configured number of low data bits; odd mode inverts.
    function automatic logic calc_parity(input logic [DATA_W-1:0] data,
                                         input logic [1:0]        bits,
                                         input logic              odd);
        logic p;
        p = odd;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < (int'(bits) + 5)) begin
                p = p ^ data[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // A bit period ends on the tick that completes OVERSAMPLE ticks.
    assign bit_end_s  = bclk_tick && (tick_cnt_r == TICK_W'(OVERSAMPLE - 1));
    // Index of the final data bit for the snapshotted word length (5..8 bits).
    assign last_bit_s = BIT_W'(data_bits_r) + BIT_W'(4);

    // Frame sequencer: state, counters, snapshot and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            tick_cnt_r  <= TICK_W'(0);
            bit_cnt_r   <= BIT_W'(0);
            stop_cnt_r  <= 1'b0;
            shreg_r     <= DATA_W'(0);
            data_bits_r <= 2'd0;
            parity_en_r <= 1'b0;
            stop2_r     <= 1'b0;
            parity_r    <= 1'b0;
            txd         <= 1'b1;
            tx_ready    <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            bclk_start  <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            if (state_r == S_IDLE) begin
                // Ticks are ignored here; the generator is held cleared.
                tick_cnt_r <= TICK_W'(0);
                if (tx_valid && tx_ready) begin
                    shreg_r     <= tx_data;
                    data_bits_r <= cfg_data_bits;
                    parity_en_r <= cfg_parity_en;
                    stop2_r     <= cfg_stop2;
                    parity_r    <= calc_parity(tx_data, cfg_data_bits, cfg_parity_odd);
                    bit_cnt_r   <= BIT_W'(0);
                    stop_cnt_r  <= 1'b0;
                    state_r     <= S_START;
                    txd         <= 1'b0;
                    tx_ready    <= 1'b0;
                    tx_busy     <= 1'b1;
                    bclk_start  <= 1'b0;
                end
            end else begin
                if (bclk_tick) begin
                    if (bit_end_s) begin
                        tick_cnt_r <= TICK_W'(0);
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                    end
                end
                if (bit_end_s) begin
                    case (state_r)
                        S_START: begin
                            state_r   <= S_DATA;
                            bit_cnt_r <= BIT_W'(0);
                            txd       <= shreg_r[0];
                        end
                        S_DATA: begin
                            if (bit_cnt_r == last_bit_s) begin
                                if (parity_en_r) begin
                                    state_r <= S_PARITY;
                                    txd     <= parity_r;
                                end else begin
                                    state_r    <= S_STOP;
                                    stop_cnt_r <= 1'b0;
                                    txd        <= 1'b1;
                                end
                            end else begin
                                shreg_r   <= shreg_r >> 1;
                                txd       <= shreg_r[1];
                                bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            end
                        end
                        S_PARITY: begin
                            state_r    <= S_STOP;
                            stop_cnt_r <= 1'b0;
                            txd        <= 1'b1;
                        end
                        S_STOP: begin
                            if (stop2_r && !stop_cnt_r) begin
                                stop_cnt_r <= 1'b1;
                                txd        <= 1'b1;
                            end else begin
                                state_r    <= S_IDLE;
                                txd        <= 1'b1;
                                tx_done    <= 1'b1;
                                tx_busy    <= 1'b0;
                                tx_ready   <= 1'b1;
                                bclk_start <= 1'b1;
                            end
                        end
                        default: begin
                            // Unreachable encoding: recover to an idle line.
                            state_r    <= S_IDLE;
                            txd        <= 1'b1;
                            tx_busy    <= 1'b0;
                            tx_ready   <= 1'b1;
                            bclk_start <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

endmodule
